dist_sram_nxn_b: RTL and testbench



---
 rtl/graph_pkg.sv | 52 +++++
 rtl/dist_sram_nxn_b.sv | 72 +++++++
 tb/tb_dist_sram_nxn_b.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/graph_pkg.sv
// Shared graph-engine constants: distance-matrix geometry and worker field widths.
package graph_pkg;

  // Distance matrix geometry
  localparam int unsigned D               = 256;
  localparam int unsigned DIST_BW         = 1;
  localparam int unsigned DIST_ADDR_SPACE = 16;
  localparam int unsigned N               = 4096;
  localparam int unsigned DIST_WORD_BW    = D * DIST_BW;
  localparam int unsigned DIST_DEPTH      = 1 << DIST_ADDR_SPACE;

  // Index widths derived from the geometry
  localparam int unsigned VID_BW      = $clog2(N);
  localparam int unsigned DIST_BIT_BW = $clog2(D);

  // Worker-side field widths
  localparam int unsigned LOC_BW  = VID_BW;
  localparam int unsigned NEXT_BW = VID_BW + 1;
  localparam int unsigned PRO_BW  = 8;

  typedef logic [VID_BW-1:0]          vid_t;
  typedef logic [DIST_ADDR_SPACE-1:0] dist_addr_t;
  typedef logic [DIST_BIT_BW-1:0]     dist_bit_t;
  typedef logic [DIST_WORD_BW-1:0]    dist_word_t;

  // Location of matrix element (row, col) inside the distance memory
  typedef struct packed {
    dist_addr_t addr;
    dist_bit_t  bit_idx;
  } dist_loc_t;

  // Word address holding matrix element (row, col): (row*N + col) / D
  function automatic dist_addr_t dist_word_addr(input vid_t row, input vid_t col);
    logic [2*VID_BW-1:0] flat;
    flat = {row, col};
    return DIST_ADDR_SPACE'(flat >> DIST_BIT_BW);
  endfunction

  // Bit position of matrix element (row, col) inside its word: col % D
  function automatic dist_bit_t dist_bit_idx(input vid_t col);
    return DIST_BIT_BW'(col);
  endfunction

  // Combined word/bit location
  function automatic dist_loc_t dist_locate(input vid_t row, input vid_t col);
    dist_loc_t loc;
    loc.addr    = dist_word_addr(row, col);
    loc.bit_idx = dist_bit_idx(col);
    return loc;
  endfunction

endpackage

// File: rtl/dist_sram_nxn_b.sv
// Behavioural N x N distance-matrix SRAM: one write port, one registered read port.
module dist_sram_nxn_b
  import graph_pkg::*;
#(
  parameter int unsigned DATA_BW = DIST_WORD_BW,
  parameter int unsigned ADDR_BW = DIST_ADDR_SPACE,
  parameter int unsigned DEPTH   = DIST_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wsb,
  input  logic [DATA_BW-1:0] wdata,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [DATA_BW-1:0] rdata
);

  // Storage array; never cleared, power-up contents undefined
  logic [DATA_BW-1:0] mem [DEPTH];

  logic waddr_x_c;
  logic raddr_x_c;
  logic we_c;

  assign waddr_x_c = $isunknown(waddr);
  assign raddr_x_c = $isunknown(raddr);
  // Writes are dropped while reset is held or the address is unknown
  assign we_c      = ~wsb & ~rst & ~waddr_x_c;

  // Write port: full-word write, no byte mask
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: read-first against a same-address write, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (raddr_x_c) begin
      rdata <= 'x;
    end else begin
      rdata <= mem[raddr];
    end
  end

`ifndef SYNTHESIS
  // Flag unknown addresses on active operations
  always @(posedge clk) begin
    if (!rst) begin
      if (!wsb && waddr_x_c) begin
        $warning("dist_sram_nxn_b: write with unknown waddr dropped");
      end
      if (raddr_x_c) begin
        $warning("dist_sram_nxn_b: read with unknown raddr returns X");
      end
    end
  end

  // Preload one word directly into the array
  task automatic load_word(input logic [ADDR_BW-1:0] addr, input logic [DATA_BW-1:0] data);
    mem[addr] = data;
  endtask

  // Show one stored word
  task automatic dump_word(input logic [ADDR_BW-1:0] addr);
    $display("dist_sram_nxn_b mem[%0h] = %h", addr, mem[addr]);
  endtask
`endif

endmodule

// File: tb/tb_dist_sram_nxn_b.sv
// Directed self-checking bench for dist_sram_nxn_b.
module tb_dist_sram_nxn_b;
  import graph_pkg::*;

  localparam int unsigned DW = 256;
  localparam int unsigned AW = 16;

  logic          clk;
  logic          rst;
  logic          wsb;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  int checks;
  int failures;

  dist_sram_nxn_b dut (
    .clk   (clk),
    .rst   (rst),
    .wsb   (wsb),
    .wdata (wdata),
    .waddr (waddr),
    .raddr (raddr),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Deterministic per-address pattern
  function automatic logic [DW-1:0] pat(input int unsigned a);
    logic [DW-1:0] w;
    for (int j = 0; j < 8; j++) begin
      w[j*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(j) * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    return w;
  endfunction

  // Single write with no read of interest
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wsb = 1'b0; waddr = a; wdata = d;
    cycle();
    wsb = 1'b1;
  endtask

  // Read one address; result valid on return
  task automatic do_read(input logic [AW-1:0] a);
    wsb = 1'b1; raddr = a;
    cycle();
  endtask

  task automatic test_reset();
    logic [DW-1:0] ones;
    ones = '1;
    rst = 1'b1; wsb = 1'b1; waddr = '0; raddr = '0; wdata = '0;
    #3;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL reset_init: got %h expected 0", rdata);
    end
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    do_write(16'h0001, ones);
    do_write(16'h0002, pat(2));
    do_read(16'h0001);
    checks++;
    if (rdata !== ones) begin
      failures++;
      $display("FAIL reset_preload: got %h expected all ones", rdata);
    end
    // Assert reset between edges: rdata must clear before the next edge
    rst = 1'b1;
    #1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 0", rdata);
    end
    // Write attempted while reset held must be suppressed
    wsb = 1'b0; waddr = 16'h0002; wdata = pat(99); raddr = 16'h0001;
    cycle(); cycle();
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected 0", rdata);
    end
    wsb = 1'b1;
    rst = 1'b0;
    do_read(16'h0002);
    checks++;
    if (rdata !== pat(2)) begin
      failures++;
      $display("FAIL reset_write_blocked: got %h expected %h", rdata, pat(2));
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] w;
    w = {{16{8'hA5}}, 128'h0};
    do_write(16'h0005, w);
    do_read(16'h0005);
    checks++;
    if (rdata !== w) begin
      failures++;
      $display("FAIL write_read: got %h expected %h", rdata, w);
    end
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] ones;
    ones = '1;
    do_write(16'h0007, '0);
    wsb = 1'b0; waddr = 16'h0007; wdata = ones; raddr = 16'h0007;
    cycle();
    wsb = 1'b1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL rdw_old: got %h expected 0", rdata);
    end
    do_read(16'h0007);
    checks++;
    if (rdata !== ones) begin
      failures++;
      $display("FAIL rdw_new: got %h expected all ones", rdata);
    end
  endtask

  task automatic test_wsb_high();
    do_write(16'h0003, 256'h2);
    wsb = 1'b1; waddr = 16'h0003; wdata = 256'h1;
    cycle();
    do_read(16'h0003);
    checks++;
    if (rdata !== 256'h2) begin
      failures++;
      $display("FAIL wsb_high: got %h expected 2", rdata);
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    lo = {8{32'h0BAD_F00D}};
    hi = {8{32'hCAFE_1234}};
    do_write(16'h0000, lo);
    do_write(16'hFFFF, hi);
    do_read(16'h0000);
    checks++;
    if (rdata !== lo) begin
      failures++;
      $display("FAIL boundary_lo: got %h expected %h", rdata, lo);
    end
    do_read(16'hFFFF);
    checks++;
    if (rdata !== hi) begin
      failures++;
      $display("FAIL boundary_hi: got %h expected %h", rdata, hi);
    end
  endtask

  task automatic test_bit_order();
    dist_addr_t a;
    dist_bit_t  b;
    logic [DW-1:0] w;
    // row 1, col 300 -> flat 4396 -> word 17, bit 44
    a = dist_word_addr(12'd1, 12'd300);
    b = dist_bit_idx(12'd300);
    checks++;
    if (a !== 16'd17 || b !== 8'd44) begin
      failures++;
      $display("FAIL bit_loc: got addr %0d bit %0d expected 17 44", a, b);
    end
    w = '0;
    w[44] = 1'b1;
    do_write(16'd17, w);
    do_read(16'd17);
    checks++;
    if (rdata[44] !== 1'b1 || rdata !== (256'h1 << 44)) begin
      failures++;
      $display("FAIL bit_order: got %h expected bit 44 only", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int errs;
    // Streaming writes with a concurrent lagging read of the prior address
    for (int i = 0; i < 256; i++) begin
      wsb = 1'b0; waddr = AW'(16'h1000 + i); wdata = pat(i);
      raddr = AW'(16'h1000 + i - 1);
      cycle();
      if (i > 1) begin
        checks++;
        if (rdata !== pat(i - 1)) begin
          failures++;
          $display("FAIL b2b_wr_rd[%0d]: got %h expected %h", i, rdata, pat(i - 1));
        end
      end
    end
    wsb = 1'b1;
    // Sweep one read per cycle, 1-cycle lag
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      raddr = AW'(16'h1000 + i);
      cycle();
      checks++;
      if (rdata !== pat(i)) begin
        failures++;
        errs++;
        if (errs < 4) $display("FAIL b2b_sweep[%0d]: got %h expected %h", i, rdata, pat(i));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_write(16'h0100, pat(16'h100));
    raddr = 16'h0005;
    cycle();
    // Write in flight when reset rises: must be lost
    wsb = 1'b0; waddr = 16'h0100; wdata = pat(7777);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL midburst_async: got %h expected 0", rdata);
    end
    cycle();
    rst = 1'b0; wsb = 1'b1; raddr = 16'h0100;
    cycle();
    checks++;
    if (rdata !== pat(16'h100)) begin
      failures++;
      $display("FAIL midburst_resume: got %h expected %h", rdata, pat(16'h100));
    end
    do_read(16'h0005);
    checks++;
    if (rdata !== {{16{8'hA5}}, 128'h0}) begin
      failures++;
      $display("FAIL midburst_other: got %h expected A5 upper half", rdata);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_wsb_high();
    test_boundary();
    test_bit_order();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
